// File: rtl/serial_rx.sv
// Asynchronous 8N1 serial receiver with mid-bit sampling, one-cycle Valid strobe and error flags.
// Define RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module serial_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              RxD,
  output logic [DATA_W-1:0] Data,
  output logic              Valid,
  output logic              FrameErr,
  output logic              ParityErr,
  output logic              Busy
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(HALF);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              rx_s;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              parity_ok;

`ifdef RX_PARITY_EN
  logic pok_q, pok_d;
  logic perr_q, perr_d;
  assign parity_ok = pok_q;
  assign ParityErr = perr_q;
`else
  assign parity_ok = 1'b1;
  assign ParityErr = 1'b0;
`endif

  assign rx_s     = sync_q[1];
  assign Data     = data_q;
  assign Valid    = valid_q;
  assign FrameErr = ferr_q;
  assign Busy     = (state_q != StIdle);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
      pok_q   <= 1'b1;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], RxD};
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
      pok_q   <= pok_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
`ifdef RX_PARITY_EN
    pok_d   = pok_q;
    perr_d  = perr_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d = '0;
          idx_d = '0;
          // A line back high at mid start bit is a glitch, not a frame
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          if (idx_q == LastIdx) begin
`ifdef RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef RX_PARITY_EN
      StParity: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          pok_d   = ~(^shift_q ^ rx_s);
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (rx_s) begin
            ferr_d  = 1'b0;
            state_d = StIdle;
            if (parity_ok) begin
              data_d  = shift_q;
              valid_d = 1'b1;
`ifdef RX_PARITY_EN
              perr_d  = 1'b0;
            end else begin
              perr_d  = 1'b1;
`endif
            end
          end else begin
            ferr_d  = 1'b1;
`ifdef RX_PARITY_EN
            perr_d  = ~parity_ok;
`endif
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
